// File: rtl/cache_fill_fsm_if.sv
// Cache fill bus: groups the cache-side miss/stall/write signals and the
// main-memory read channel used by the cache line fill controller.
//   master : the fill controller (drives stall, memory reads, cache writes)
//   slave  : the surrounding cache + memory (drives miss info, read returns)
// Signals:
//   miss_detected     - current memory-stage access misses
//   miss_address      - byte address of the missing access
//   memory_data       - read data returned by main memory
//   memory_data_valid - memory_data valid this cycle, one pulse per read
//   fsm_busy          - pipeline stall request
//   memory_read       - read request, one word per cycle
//   memory_address    - address of the current memory read
//   write_data_array  - cache data array write strobe
//   write_tag_array   - cache tag/valid/LRU write strobe
//   cache_address     - cache address for data/tag writes
//   cache_data        - word written into the cache data array
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic [15:0]           memory_data;
  logic                  memory_data_valid;
  logic                  fsm_busy;
  logic                  memory_read;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] cache_address;
  logic [15:0]           cache_data;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, memory_read, memory_address,
           write_data_array, write_tag_array, cache_address, cache_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, memory_read, memory_address,
           write_data_array, write_tag_array, cache_address, cache_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller. On a miss it reads the 16-byte block
// (8 x 16-bit words) from multi-cycle main memory, writes each returned
// word into the cache data array, then writes the tag metadata once and
// drops the pipeline stall.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - cache_fill_fsm_if.master (miss info in, memory reads out,
//         memory returns in, cache writes and stall out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a miss; all strobes low, no stall
// FILL  | issuing 8 reads and writing each returned word into the cache
// TAG   | one-cycle tag/valid/LRU write, then back to IDLE
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_fsm_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] TAG  = 2'd2;

  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = {{(ADDR_WIDTH-4){1'b1}}, 4'b0000};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            issue_cnt;
  logic [2:0]            ret_cnt;
  logic                  issue_done;

  logic in_fill;
  logic rd_active;
  logic wr_active;

  assign in_fill   = (state == FILL);
  assign rd_active = in_fill && !issue_done;
  // Returns are only meaningful during FILL; strays in IDLE/TAG are dropped.
  assign wr_active = in_fill && bus.memory_data_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            state      <= FILL;
            base       <= bus.miss_address & BLOCK_MASK;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            issue_done <= 1'b0;
          end
        end
        FILL: begin
          if (!issue_done) begin
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == LAST_WORD) issue_done <= 1'b1;
          end
          if (bus.memory_data_valid) begin
            ret_cnt <= ret_cnt + 3'd1;
            if (ret_cnt == LAST_WORD) state <= TAG;
          end
        end
        TAG:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Word offsets come purely from the 3-bit counters, so a fill never
  // carries into bit 4 and stays inside its 16-byte block.
  always_comb begin
    bus.fsm_busy         = (state == FILL) || (state == TAG);
    bus.memory_read      = rd_active;
    bus.memory_address   = '0;
    bus.write_data_array = wr_active;
    bus.write_tag_array  = (state == TAG);
    bus.cache_address    = '0;
    if (rd_active) begin
      bus.memory_address = {base[ADDR_WIDTH-1:4], issue_cnt, 1'b0};
    end
    if (wr_active) begin
      bus.cache_address = {base[ADDR_WIDTH-1:4], ret_cnt, 1'b0};
    end else if (state == TAG) begin
      bus.cache_address = base;
    end
  end

  assign bus.cache_data = bus.memory_data;

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler directly downstream of the cache's miss_detected output and upstream of its data_wr / write_tag_array inputs.
- On a miss, fetches the full 16-byte block (8 x 16-bit words) from the multi-cycle main memory and writes each returned word into the cache data array.
- Then writes the tag/valid/LRU metadata once and releases the pipeline stall.

Parameters:
ADDR_WIDTH, 16, byte-address width of miss_address, memory_address, cache_address
WORDS_PER_BLOCK, 8, words per cache block; fixed at 8, so counters are 3 bits wide

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
miss_detected  input  1  from cache; high while the current memory-stage access misses
miss_address  input  ADDR_WIDTH  byte address of the missing access
memory_data  input  16  read data returned by main memory
memory_data_valid  input  1  memory_data valid this cycle; one pulse per issued read, in order
fsm_busy  output  1  stall request to pipeline; high while a fill is in progress
memory_read  output  1  read request to memory, one word per cycle
memory_address  output  ADDR_WIDTH  address of the current memory read
write_data_array  output  1  drives cache data_wr
write_tag_array  output  1  drives cache write_tag_array (one-cycle pulse)
cache_address  output  ADDR_WIDTH  address presented to the cache during the fill
cache_data  output  16  word to write into the cache; equals memory_data

Behaviour:
- Reset (rst=0, async): state=IDLE, base=0, issue_cnt=0, ret_cnt=0.
- All outputs 0 during and after reset until the first miss.
- States:
  - IDLE: fsm_busy=0, all write/read outputs 0.
  - FILL: fsm_busy=1.
  - TAG: fsm_busy=1, write_tag_array=1.
- IDLE -> FILL: on a clock edge where miss_detected=1.
  - Latch base = {miss_address[15:4], 4'b0000}.
  - Clear both counters.
- FILL, issue side:
  - memory_read=1 while issue_done=0.
  - memory_address = {base[15:4], issue_cnt, 1'b0}.
  - issue_cnt increments each cycle.
  - After issuing word 7, set issue_done; memory_read=0 for the rest of the fill.
  - Exactly 8 consecutive read cycles, starting the first cycle in FILL.
- FILL, return side (Mealy on memory_data_valid):
  - When valid=1: write_data_array=1, cache_address = {base[15:4], ret_cnt, 1'b0}, cache_data = memory_data.
  - ret_cnt increments at the edge.
  - Gaps in valid are tolerated; write_data_array=0 and ret_cnt holds.
- FILL -> TAG: at the edge where memory_data_valid=1 and ret_cnt=7.
- TAG:
  - write_tag_array=1, write_data_array=0, memory_read=0.
  - cache_address = base.
  - Lasts exactly 1 cycle, then TAG -> IDLE unconditionally.
- Address arithmetic:
  - Word offset comes only from the 3-bit counter concatenation; no carry into bit 4.
  - The block never crosses a 16-byte boundary; base 0xFFF0 issues 0xFFF0..0xFFFE.
- Ignored inputs:
  - miss_detected in FILL/TAG is ignored; no re-latch of base.
  - memory_data_valid in IDLE or TAG is ignored; no write, no counter change.
- Back-to-back misses:
  - In the first IDLE cycle after TAG, miss_detected is sampled again.
  - If it is 1, a new fill starts at the next edge.
  - The cache clears its miss latch on write_tag_array, so a stale miss reads 0 there.
- Reset mid-fill: immediate return to IDLE with all outputs 0; in-flight memory returns after reset are ignored.
- cache_data = memory_data combinationally at all times.
- While fsm_busy=1, the pipeline holds miss_address stable; the block uses only the latched base.

Test Plan:
1. Basic fill, memory latency 4:
   - Stimulus: miss_address=0x1234, miss_detected=1 at edge T.
   - memory_read at T+1..T+8 with addresses 0x1230, 0x1232, ..., 0x123E.
   - valid T+5..T+12 gives 8 write_data_array pulses, cache_address 0x1230..0x123E, cache_data equal to memory_data.
   - write_tag_array=1 only at T+13 with cache_address=0x1230; fsm_busy=1 for T+1..T+13, 0 at T+14.
2. Irregular returns:
   - Stimulus: memory_data_valid with 1-3 cycle gaps between the 8 pulses.
   - Exactly 8 writes in order 0x..0 to 0x..E; write_tag_array only the cycle after the 8th valid.
3. Reset mid-fill:
   - Stimulus: rst=0 after the 3rd return.
   - All outputs 0 immediately; the remaining 5 valids produce no write_data_array.
   - A new miss at 0x4000 starts a clean fill at 0x4000.
4. Back-to-back misses:
   - Stimulus: miss_detected high again in the IDLE cycle after TAG, new address 0xA00C.
   - New fill issues 0xA000..0xA00E; no overlap with the first fill.
5. Spurious inputs:
   - memory_data_valid pulses in IDLE produce no writes and fsm_busy stays 0.
   - miss_detected toggling during FILL leaves base unchanged.
6. Top of memory:
   - Stimulus: miss_address=0xFFFF.
   - Addresses 0xFFF0..0xFFFE, no wrap to 0x0000; write_tag_array with cache_address=0xFFF0.
